// File: rtl/playseq_gravador_sequencia.sv
// Custom-sequence recorder for PlaySeq slot 3: one-hot presses go into a 16x4 RAM,
// read back through a registered port with the same latency as the game ROMs.
module playseq_gravador_sequencia #(
  parameter int TIMEOUT_M = 5000,
  parameter int TIMEOUT_N = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       finalizar,
  input  logic [3:0] botoes,
  input  logic [3:0] rd_endereco,
  output logic [3:0] rd_dado,
  output logic       pronto,
  output logic       gravando,
  output logic [3:0] tamanho,
  output logic       erro_timeout,
  output logic [3:0] leds,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    ESPERA   = 3'd1,
    REGISTRA = 3'd2,
    GRAVA    = 3'd3,
    PROXIMO  = 3'd4,
    CONCLUI  = 3'd5,
    TIMEOUT  = 3'd6
  } estado_t;

  localparam logic [TIMEOUT_N-1:0] TMO_LAST = TIMEOUT_N'(TIMEOUT_M - 1);

  estado_t              estado_q;
  logic [3:0]           addr_q, press_q, tam_q, rd_q;
  logic [TIMEOUT_N-1:0] tmo_q;
  logic                 btn_q, pronto_q, erro_q;
  logic [3:0]           mem [16];

  logic btn_any, btn_rise, one_hot, we;
  assign btn_any  = |botoes;
  assign btn_rise = btn_any & ~btn_q;
  assign one_hot  = btn_any && ((botoes & (botoes - 4'd1)) == 4'd0);
  assign we       = (estado_q == GRAVA);

  // Edge detector runs in every state, so a button held through the write
  // sequence gives no fresh edge when ESPERA is re-entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      addr_q   <= '0;
      press_q  <= '0;
      tam_q    <= '0;
      tmo_q    <= '0;
      btn_q    <= 1'b0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      btn_q <= btn_any;
      case (estado_q)
        INICIAL, TIMEOUT: begin
          if (iniciar) begin
            estado_q <= ESPERA;
            addr_q   <= '0;
            tmo_q    <= '0;
            tam_q    <= '0;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
          end
        end
        ESPERA: begin
          tmo_q <= tmo_q + 1'b1;
          if (finalizar) begin
            if (addr_q != 4'd0) begin
              tam_q    <= addr_q - 4'd1;
              estado_q <= CONCLUI;
            end else begin
              pronto_q <= 1'b0;
              estado_q <= INICIAL;
            end
          end else if (tmo_q == TMO_LAST) begin
            erro_q   <= 1'b1;
            pronto_q <= 1'b0;
            estado_q <= TIMEOUT;
          end else if (btn_rise && one_hot) begin
            press_q  <= botoes;
            estado_q <= REGISTRA;
          end
        end
        REGISTRA: estado_q <= GRAVA;
        GRAVA: begin
          if (addr_q == 4'd15) begin
            tam_q    <= 4'd15;
            estado_q <= CONCLUI;
          end else begin
            estado_q <= PROXIMO;
          end
        end
        PROXIMO: begin
          addr_q   <= addr_q + 4'd1;
          tmo_q    <= '0;
          estado_q <= ESPERA;
        end
        CONCLUI: begin
          pronto_q <= 1'b1;
          estado_q <= INICIAL;
        end
        default: estado_q <= INICIAL;
      endcase
    end
  end

  // RAM contents survive reset; pronto=0 is what marks them invalid.
  always_ff @(posedge clock) begin
    if (we) mem[addr_q] <= press_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_q <= '0;
    else        rd_q <= mem[rd_endereco];
  end

  assign rd_dado      = rd_q;
  assign pronto       = pronto_q;
  assign erro_timeout = erro_q;
  assign tamanho      = tam_q;
  assign gravando     = (estado_q == ESPERA) || (estado_q == REGISTRA) ||
                        (estado_q == GRAVA)  || (estado_q == PROXIMO);
  assign leds         = ((estado_q == REGISTRA) || (estado_q == GRAVA)) ? press_q : 4'd0;
  assign db_estado    = {1'b0, estado_q};

endmodule

// File: tb/tb_playseq_gravador_sequencia.sv
// Directed bench for the slot-3 sequence recorder; a second instance with a
// short timeout exercises the abort path.
module tb_playseq_gravador_sequencia;

  logic       clock = 1'b0;
  logic       reset, reset2, iniciar, iniciar2, finalizar;
  logic [3:0] botoes, rd_endereco;
  logic [3:0] rd_dado, tamanho, leds, db_estado;
  logic       pronto, gravando, erro_timeout;
  logic [3:0] t_rd_dado, t_tamanho, t_leds, t_db_estado;
  logic       t_pronto, t_gravando, t_erro;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  playseq_gravador_sequencia dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .finalizar(finalizar),
    .botoes(botoes), .rd_endereco(rd_endereco), .rd_dado(rd_dado),
    .pronto(pronto), .gravando(gravando), .tamanho(tamanho),
    .erro_timeout(erro_timeout), .leds(leds), .db_estado(db_estado));

  playseq_gravador_sequencia #(.TIMEOUT_M(20), .TIMEOUT_N(13)) dut_t (
    .clock(clock), .reset(reset2), .iniciar(iniciar2), .finalizar(finalizar),
    .botoes(botoes), .rd_endereco(rd_endereco), .rd_dado(t_rd_dado),
    .pronto(t_pronto), .gravando(t_gravando), .tamanho(t_tamanho),
    .erro_timeout(t_erro), .leds(t_leds), .db_estado(t_db_estado));

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start();
    iniciar = 1'b1; tick(1); iniciar = 1'b0;
  endtask

  // Press, release, and wait until the FSM is back in ESPERA.
  task automatic press(input logic [3:0] v);
    botoes = v; tick(1); botoes = 4'd0; tick(4);
  endtask

  task automatic finish_rec();
    finalizar = 1'b1; tick(1); finalizar = 1'b0; tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b0; reset2 = 1'b0; iniciar = 1'b0; iniciar2 = 1'b0;
    finalizar = 1'b0; botoes = 4'd0; rd_endereco = 4'd0;
    tick(3);
    n_cmp++; if (db_estado !== 4'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", db_estado); end
    n_cmp++; if ({pronto, gravando, erro_timeout} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {pronto, gravando, erro_timeout}); end
    n_cmp++; if ({tamanho, leds, rd_dado} !== 12'h000) begin n_err++; $display("FAIL rst_data: got %h want 000", {tamanho, leds, rd_dado}); end
    reset = 1'b1; tick(1);
  endtask

  task automatic test_basic();
    start();
    n_cmp++; if (db_estado !== 4'd1 || gravando !== 1'b1) begin n_err++; $display("FAIL basic_espera: got st=%0d grav=%b want 1/1", db_estado, gravando); end
    botoes = 4'b0001; tick(1);
    n_cmp++; if (db_estado !== 4'd2 || leds !== 4'b0001) begin n_err++; $display("FAIL basic_registra: got st=%0d leds=%b want 2/0001", db_estado, leds); end
    botoes = 4'd0; tick(1);
    n_cmp++; if (db_estado !== 4'd3 || leds !== 4'b0001) begin n_err++; $display("FAIL basic_grava: got st=%0d leds=%b want 3/0001", db_estado, leds); end
    tick(1);
    n_cmp++; if (db_estado !== 4'd4 || leds !== 4'd0) begin n_err++; $display("FAIL basic_proximo: got st=%0d leds=%b want 4/0000", db_estado, leds); end
    tick(2);
    press(4'b0010); press(4'b0100); press(4'b1000);
    finalizar = 1'b1; tick(1); finalizar = 1'b0;
    n_cmp++; if (db_estado !== 4'd5 || pronto !== 1'b0) begin n_err++; $display("FAIL basic_conclui: got st=%0d pronto=%b want 5/0", db_estado, pronto); end
    tick(1);
    n_cmp++; if (pronto !== 1'b1 || tamanho !== 4'd3 || db_estado !== 4'd0) begin n_err++; $display("FAIL basic_done: got pronto=%b tam=%0d st=%0d want 1/3/0", pronto, tamanho, db_estado); end
    for (int i = 0; i < 4; i++) begin
      rd_endereco = 4'(i); tick(1);
      n_cmp++; if (rd_dado !== 4'(1 << i)) begin n_err++; $display("FAIL basic_ram%0d: got %b want %b", i, rd_dado, 4'(1 << i)); end
    end
    tick(10);
    n_cmp++; if (pronto !== 1'b1 || tamanho !== 4'd3) begin n_err++; $display("FAIL basic_idle: got pronto=%b tam=%0d want 1/3", pronto, tamanho); end
  endtask

  task automatic test_full16();
    start();
    n_cmp++; if (pronto !== 1'b0) begin n_err++; $display("FAIL full_clear: got pronto=%b want 0", pronto); end
    for (int i = 0; i < 16; i++) press(4'(1 << (i % 4)));
    n_cmp++; if (pronto !== 1'b1 || tamanho !== 4'd15 || db_estado !== 4'd0) begin n_err++; $display("FAIL full_done: got pronto=%b tam=%0d st=%0d want 1/15/0", pronto, tamanho, db_estado); end
    press(4'b1000);
    rd_endereco = 4'd0; tick(1);
    n_cmp++; if (rd_dado !== 4'b0001 || db_estado !== 4'd0) begin n_err++; $display("FAIL full_17th: got ram0=%b st=%0d want 0001/0", rd_dado, db_estado); end
    rd_endereco = 4'd15; tick(1);
    n_cmp++; if (rd_dado !== 4'b1000) begin n_err++; $display("FAIL full_ram15: got %b want 1000", rd_dado); end
    rd_endereco = 4'd5; tick(1);
    n_cmp++; if (rd_dado !== 4'b0010) begin n_err++; $display("FAIL full_ram5: got %b want 0010", rd_dado); end
  endtask

  task automatic test_nonhot();
    start();
    botoes = 4'b0011; tick(1);
    n_cmp++; if (db_estado !== 4'd1) begin n_err++; $display("FAIL nonhot_stay: got st=%0d want 1", db_estado); end
    botoes = 4'd0; tick(1);
    press(4'b0100);
    finish_rec();
    rd_endereco = 4'd0; tick(1);
    n_cmp++; if (rd_dado !== 4'b0100 || tamanho !== 4'd0 || pronto !== 1'b1) begin n_err++; $display("FAIL nonhot_store: got ram0=%b tam=%0d pronto=%b want 0100/0/1", rd_dado, tamanho, pronto); end
  endtask

  task automatic test_hold();
    start();
    botoes = 4'b1000; tick(50); botoes = 4'd0; tick(3);
    finish_rec();
    n_cmp++; if (tamanho !== 4'd0 || pronto !== 1'b1) begin n_err++; $display("FAIL hold_len: got tam=%0d pronto=%b want 0/1", tamanho, pronto); end
    rd_endereco = 4'd1; tick(1);
    n_cmp++; if (rd_dado !== 4'b0010) begin n_err++; $display("FAIL hold_ram1: got %b want 0010", rd_dado); end
    rd_endereco = 4'd0; tick(1);
    n_cmp++; if (rd_dado !== 4'b1000) begin n_err++; $display("FAIL hold_ram0: got %b want 1000", rd_dado); end
  endtask

  task automatic test_reset_mid();
    start();
    press(4'b0001); press(4'b0010); press(4'b0100);
    reset = 1'b0; #1;
    n_cmp++; if ({pronto, gravando, erro_timeout, tamanho, leds, rd_dado, db_estado} !== 19'd0) begin n_err++; $display("FAIL midrst_zero: got p=%b g=%b e=%b t=%0d l=%b r=%b s=%0d want all 0", pronto, gravando, erro_timeout, tamanho, leds, rd_dado, db_estado); end
    tick(1); reset = 1'b1; tick(2);
    start(); press(4'b0001);
    n_cmp++; if (pronto !== 1'b0) begin n_err++; $display("FAIL midrst_partial: got pronto=%b want 0", pronto); end
    finish_rec();
    n_cmp++; if (pronto !== 1'b1 || tamanho !== 4'd0) begin n_err++; $display("FAIL midrst_new: got pronto=%b tam=%0d want 1/0", pronto, tamanho); end
  endtask

  task automatic test_zero_final();
    start();
    finalizar = 1'b1; tick(1); finalizar = 1'b0;
    n_cmp++; if (db_estado !== 4'd0 || pronto !== 1'b0 || gravando !== 1'b0) begin n_err++; $display("FAIL zero_final: got st=%0d pronto=%b grav=%b want 0/0/0", db_estado, pronto, gravando); end
  endtask

  task automatic test_timeout();
    reset2 = 1'b1; tick(1);
    iniciar2 = 1'b1; tick(1); iniciar2 = 1'b0;
    n_cmp++; if (t_db_estado !== 4'd1) begin n_err++; $display("FAIL tmo_entry: got st=%0d want 1", t_db_estado); end
    tick(19);
    n_cmp++; if (t_db_estado !== 4'd1 || t_erro !== 1'b0) begin n_err++; $display("FAIL tmo_early: got st=%0d erro=%b want 1/0", t_db_estado, t_erro); end
    tick(1);
    n_cmp++; if (t_db_estado !== 4'd6 || t_erro !== 1'b1 || t_pronto !== 1'b0 || t_gravando !== 1'b0) begin n_err++; $display("FAIL tmo_abort: got st=%0d erro=%b pronto=%b grav=%b want 6/1/0/0", t_db_estado, t_erro, t_pronto, t_gravando); end
    tick(3);
    n_cmp++; if (t_db_estado !== 4'd6) begin n_err++; $display("FAIL tmo_hold: got st=%0d want 6", t_db_estado); end
    iniciar2 = 1'b1; tick(1); iniciar2 = 1'b0;
    n_cmp++; if (t_db_estado !== 4'd1 || t_erro !== 1'b0) begin n_err++; $display("FAIL tmo_restart: got st=%0d erro=%b want 1/0", t_db_estado, t_erro); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full16();
    test_nonhot();
    test_hold();
    test_reset_mid();
    test_zero_final();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
